// File: rtl/instr_encoder.sv
// instr_encoder: encodes RV32I instruction requests into raw words and writes them to program memory.
// Optional immediate range rejection is enabled by defining ENC_IMM_RANGE_CHECK_EN.
module instr_encoder #(
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [5:0]        in_op,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [31:0]       in_imm,
  input  logic              in_last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ready,
  output logic [ADDR_W:0]   count,
  output logic              err,
  output logic              done
);
  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;
  localparam logic [2:0] F_R = 3'd0, F_I = 3'd1, F_S = 3'd2, F_B = 3'd3, F_U = 3'd4, F_J = 3'd5, F_SH = 3'd6;
  localparam logic [6:0] OP_LD = 7'b0000011, OP_ST = 7'b0100011, OP_R = 7'b0110011, OP_IM = 7'b0010011;
  localparam logic [6:0] OP_LUI = 7'b0110111, OP_AUI = 7'b0010111, OP_BR = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111, OP_JALR = 7'b1100111;
  localparam logic [6:0] F7A = 7'b0100000, F7Z = 7'b0000000;
  state_t            r_state, w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W:0]   r_count;
  logic [31:0]       r_wdata, w_enc;
  logic              r_last, r_err, w_imm_ok, w_good, w_hs;
  logic [2:0]        w_fmt, w_f3;
  logic [6:0]        w_opc, w_f7;
  always_comb begin
    {w_fmt, w_opc, w_f3, w_f7} = {F_R, 7'd0, 3'd0, F7Z};
    case (in_op)
      6'd0:  {w_fmt, w_opc, w_f3, w_f7} = {F_I, OP_LD, 3'd0, F7Z};
      6'd1:  {w_fmt, w_opc, w_f3, w_f7} = {F_I, OP_LD, 3'd1, F7Z};
      6'd2:  {w_fmt, w_opc, w_f3, w_f7} = {F_I, OP_LD, 3'd2, F7Z};
      6'd3:  {w_fmt, w_opc, w_f3, w_f7} = {F_I, OP_LD, 3'd4, F7Z};
      6'd4:  {w_fmt, w_opc, w_f3, w_f7} = {F_I, OP_LD, 3'd5, F7Z};
      6'd5:  {w_fmt, w_opc, w_f3, w_f7} = {F_S, OP_ST, 3'd0, F7Z};
      6'd6:  {w_fmt, w_opc, w_f3, w_f7} = {F_S, OP_ST, 3'd1, F7Z};
      6'd7:  {w_fmt, w_opc, w_f3, w_f7} = {F_S, OP_ST, 3'd2, F7Z};
      6'd8:  {w_fmt, w_opc, w_f3, w_f7} = {F_R, OP_R, 3'd1, F7Z};
      6'd9:  {w_fmt, w_opc, w_f3, w_f7} = {F_SH, OP_IM, 3'd1, F7Z};
      6'd10: {w_fmt, w_opc, w_f3, w_f7} = {F_R, OP_R, 3'd5, F7Z};
      6'd11: {w_fmt, w_opc, w_f3, w_f7} = {F_SH, OP_IM, 3'd5, F7Z};
      6'd12: {w_fmt, w_opc, w_f3, w_f7} = {F_R, OP_R, 3'd5, F7A};
      6'd13: {w_fmt, w_opc, w_f3, w_f7} = {F_SH, OP_IM, 3'd5, F7A};
      6'd14: {w_fmt, w_opc, w_f3, w_f7} = {F_R, OP_R, 3'd0, F7Z};
      6'd15: {w_fmt, w_opc, w_f3, w_f7} = {F_I, OP_IM, 3'd0, F7Z};
      6'd16: {w_fmt, w_opc, w_f3, w_f7} = {F_R, OP_R, 3'd0, F7A};
      6'd17: {w_fmt, w_opc, w_f3, w_f7} = {F_U, OP_LUI, 3'd0, F7Z};
      6'd18: {w_fmt, w_opc, w_f3, w_f7} = {F_U, OP_AUI, 3'd0, F7Z};
      6'd19: {w_fmt, w_opc, w_f3, w_f7} = {F_R, OP_R, 3'd4, F7Z};
      6'd20: {w_fmt, w_opc, w_f3, w_f7} = {F_I, OP_IM, 3'd4, F7Z};
      6'd21: {w_fmt, w_opc, w_f3, w_f7} = {F_R, OP_R, 3'd6, F7Z};
      6'd22: {w_fmt, w_opc, w_f3, w_f7} = {F_I, OP_IM, 3'd6, F7Z};
      6'd23: {w_fmt, w_opc, w_f3, w_f7} = {F_R, OP_R, 3'd7, F7Z};
      6'd24: {w_fmt, w_opc, w_f3, w_f7} = {F_I, OP_IM, 3'd7, F7Z};
      6'd25: {w_fmt, w_opc, w_f3, w_f7} = {F_R, OP_R, 3'd2, F7Z};
      6'd26: {w_fmt, w_opc, w_f3, w_f7} = {F_I, OP_IM, 3'd2, F7Z};
      6'd27: {w_fmt, w_opc, w_f3, w_f7} = {F_R, OP_R, 3'd3, F7Z};
      6'd28: {w_fmt, w_opc, w_f3, w_f7} = {F_I, OP_IM, 3'd3, F7Z};
      6'd29: {w_fmt, w_opc, w_f3, w_f7} = {F_B, OP_BR, 3'd0, F7Z};
      6'd30: {w_fmt, w_opc, w_f3, w_f7} = {F_B, OP_BR, 3'd1, F7Z};
      6'd31: {w_fmt, w_opc, w_f3, w_f7} = {F_B, OP_BR, 3'd4, F7Z};
      6'd32: {w_fmt, w_opc, w_f3, w_f7} = {F_B, OP_BR, 3'd5, F7Z};
      6'd33: {w_fmt, w_opc, w_f3, w_f7} = {F_B, OP_BR, 3'd6, F7Z};
      6'd34: {w_fmt, w_opc, w_f3, w_f7} = {F_B, OP_BR, 3'd7, F7Z};
      6'd35: {w_fmt, w_opc, w_f3, w_f7} = {F_J, OP_JAL, 3'd0, F7Z};
      6'd36: {w_fmt, w_opc, w_f3, w_f7} = {F_I, OP_JALR, 3'd0, F7Z};
      default: ;
    endcase
  end
  always_comb begin
    w_enc = '0;
    case (w_fmt)
      F_R:  w_enc = {w_f7, in_rs2, in_rs1, w_f3, in_rd, w_opc};
      F_I:  w_enc = {in_imm[11:0], in_rs1, w_f3, in_rd, w_opc};
      F_SH: w_enc = {w_f7, in_imm[4:0], in_rs1, w_f3, in_rd, w_opc};
      F_S:  w_enc = {in_imm[11:5], in_rs2, in_rs1, w_f3, in_imm[4:0], w_opc};
      F_B:  w_enc = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, w_f3, in_imm[4:1], in_imm[11], w_opc};
      F_U:  w_enc = {in_imm[31:12], in_rd, w_opc};
      F_J:  w_enc = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, w_opc};
      default: ;
    endcase
  end
`ifdef ENC_IMM_RANGE_CHECK_EN
  // Signed range checks reduce to "all bits above the field MSB equal the sign".
  always_comb begin
    w_imm_ok = 1'b1;
    case (w_fmt)
      F_I, F_S: w_imm_ok = &in_imm[31:11] | ~|in_imm[31:11];
      F_SH:     w_imm_ok = ~|in_imm[31:5];
      F_B:      w_imm_ok = (&in_imm[31:12] | ~|in_imm[31:12]) & ~in_imm[0];
      F_J:      w_imm_ok = (&in_imm[31:20] | ~|in_imm[31:20]) & ~in_imm[0];
      F_U:      w_imm_ok = ~|in_imm[11:0];
      default: ;
    endcase
  end
`else
  assign w_imm_ok = 1'b1;
`endif
  assign w_good = (in_op <= 6'd36) && w_imm_ok;
  assign w_hs = (r_state == WRITE) && mem_ready;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = (in_valid && w_good) ? WRITE : IDLE;
      WRITE:   w_next = mem_ready ? (r_last ? DONE : IDLE) : WRITE;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_addr  <= ADDR_W'(BASE_ADDR);
      r_count <= '0;
      r_wdata <= '0;
      r_last  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE) begin
        if (start) begin
          r_addr  <= ADDR_W'(BASE_ADDR);
          r_count <= '0;
          r_err   <= 1'b0;
        end
        if (in_valid && w_good) begin
          r_wdata <= w_enc;
          r_last  <= in_last;
        end
        if (in_valid && !w_good) r_err <= 1'b1;
      end
      if (w_hs) begin
        r_addr <= r_addr + ADDR_W'(1);
        if (!r_count[ADDR_W]) r_count <= r_count + (ADDR_W+1)'(1);
      end
    end
  end
  assign in_ready  = (r_state == IDLE);
  assign mem_we    = (r_state == WRITE);
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign count     = r_count;
  assign err       = r_err;
  assign done      = (r_state == DONE);
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed-vector bench for instr_encoder with a 2-bit address to exercise wrap and saturation.
module tb_instr_encoder;
  localparam int AW = 2;
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0, in_valid = 1'b0, in_last = 1'b0, mem_ready = 1'b1;
  logic [5:0]    in_op = '0;
  logic [4:0]    in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [31:0]   in_imm = '0;
  logic          in_ready, mem_we, err, done;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [AW:0]   count;
  int vec = 0;
  int bad = 0;
  instr_encoder #(.ADDR_W(AW), .BASE_ADDR(0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .in_last(in_last), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .count(count), .err(err), .done(done)
  );
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic req(input logic [5:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                     input logic [4:0] rs2, input logic [31:0] imm, input logic last, input logic st);
    in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm; in_last = last;
    start = st; in_valid = 1'b1;
  endtask
  task automatic clr();
    start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
  endtask
  task automatic test_reset();
    #2;
    vec++; if ({mem_we, err, done} !== 3'b000) begin bad++; $display("FAIL reset_flags got %b want 000", {mem_we, err, done}); end
    vec++; if (mem_addr !== 2'd0 || count !== 3'd0) begin bad++; $display("FAIL reset_addr_count got %0d/%0d want 0/0", mem_addr, count); end
    vec++; if (mem_wdata !== 32'h0) begin bad++; $display("FAIL reset_wdata got %h want 0", mem_wdata); end
    rst_n = 1'b1;
    tick();
    vec++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got %b want 1", in_ready); end
  endtask
  task automatic test_addi();
    req(6'd15, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0, 1'b1);
    tick(); clr();
    vec++; if (mem_we !== 1'b1 || in_ready !== 1'b0) begin bad++; $display("FAIL addi_we got we=%b rdy=%b want 1/0", mem_we, in_ready); end
    vec++; if (mem_addr !== 2'd0 || mem_wdata !== 32'h00500093) begin bad++; $display("FAIL addi_word got %0d:%h want 0:00500093", mem_addr, mem_wdata); end
    tick();
    vec++; if (count !== 3'd1 || mem_we !== 1'b0 || mem_addr !== 2'd1) begin bad++; $display("FAIL addi_after got cnt=%0d we=%b addr=%0d want 1/0/1", count, mem_we, mem_addr); end
  endtask
  task automatic test_r_type();
    req(6'd14, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0, 1'b1);
    tick(); clr();
    vec++; if (mem_we !== 1'b1 || mem_addr !== 2'd0 || mem_wdata !== 32'h002081B3) begin bad++; $display("FAIL add_word got %b %0d:%h want 1 0:002081B3", mem_we, mem_addr, mem_wdata); end
    tick();
    vec++; if (done !== 1'b0 || count !== 3'd1) begin bad++; $display("FAIL add_after got done=%b cnt=%0d want 0/1", done, count); end
    req(6'd16, 5'd3, 5'd1, 5'd2, 32'd0, 1'b1, 1'b0);
    tick(); clr();
    vec++; if (mem_we !== 1'b1 || mem_addr !== 2'd1 || mem_wdata !== 32'h402081B3) begin bad++; $display("FAIL sub_word got %b %0d:%h want 1 1:402081B3", mem_we, mem_addr, mem_wdata); end
    tick();
    vec++; if (done !== 1'b1 || in_ready !== 1'b0 || count !== 3'd2) begin bad++; $display("FAIL done_pulse got done=%b rdy=%b cnt=%0d want 1/0/2", done, in_ready, count); end
    tick();
    vec++; if (done !== 1'b0 || in_ready !== 1'b1 || mem_addr !== 2'd2) begin bad++; $display("FAIL done_end got done=%b rdy=%b addr=%0d want 0/1/2", done, in_ready, mem_addr); end
  endtask
  task automatic test_formats();
    logic [5:0]  ops [9] = '{6'd29, 6'd7, 6'd35, 6'd13, 6'd17, 6'd30, 6'd3, 6'd27, 6'd36};
    logic [4:0]  rds [9] = '{5'd0, 5'd0, 5'd1, 5'd5, 5'd2, 5'd0, 5'd4, 5'd7, 5'd1};
    logic [4:0]  r1s [9] = '{5'd1, 5'd1, 5'd0, 5'd6, 5'd0, 5'd1, 5'd3, 5'd8, 5'd5};
    logic [4:0]  r2s [9] = '{5'd2, 5'd2, 5'd0, 5'd0, 5'd0, 5'd2, 5'd0, 5'd9, 5'd0};
    logic [31:0] imms [9] = '{32'd8, 32'd4, 32'd2048, 32'd3, 32'h12345000, 32'hFFFFFFFC, 32'hFFFFFFFF, 32'd0, 32'd0};
    logic [31:0] exps [9] = '{32'h00208463, 32'h0020A223, 32'h001000EF, 32'h40335293, 32'h12345137,
                              32'hFE209EE3, 32'hFFF1C203, 32'h009433B3, 32'h000280E7};
    for (int i = 0; i < 9; i++) begin
      req(ops[i], rds[i], r1s[i], r2s[i], imms[i], 1'b0, 1'b1);
      tick(); clr();
      vec++; if (mem_we !== 1'b1 || mem_addr !== 2'd0 || mem_wdata !== exps[i]) begin bad++; $display("FAIL fmt_%0d got %b %0d:%h want 1 0:%h", i, mem_we, mem_addr, mem_wdata, exps[i]); end
      tick();
    end
  endtask
  task automatic test_stall();
    req(6'd15, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0, 1'b1);
    tick(); clr();
    tick();
    mem_ready = 1'b0;
    req(6'd14, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0, 1'b0);
    tick(); clr();
    for (int i = 0; i < 3; i++) begin
      start = (i == 1);
      vec++; if (mem_we !== 1'b1 || in_ready !== 1'b0 || mem_addr !== 2'd1 || mem_wdata !== 32'h002081B3) begin bad++; $display("FAIL stall_%0d got we=%b rdy=%b %0d:%h want 1/0 1:002081B3", i, mem_we, in_ready, mem_addr, mem_wdata); end
      tick();
    end
    start = 1'b0;
    vec++; if (mem_we !== 1'b1 || count !== 3'd1) begin bad++; $display("FAIL stall_hold got we=%b cnt=%0d want 1/1", mem_we, count); end
    mem_ready = 1'b1;
    tick();
    vec++; if (mem_we !== 1'b0 || count !== 3'd2 || mem_addr !== 2'd2) begin bad++; $display("FAIL stall_release got we=%b cnt=%0d addr=%0d want 0/2/2", mem_we, count, mem_addr); end
  endtask
  task automatic test_illegal();
    req(6'd40, 5'd1, 5'd0, 5'd0, 32'd0, 1'b0, 1'b0);
    tick(); clr();
    vec++; if (err !== 1'b1 || mem_we !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL illegal_err got err=%b we=%b rdy=%b want 1/0/1", err, mem_we, in_ready); end
    tick();
    vec++; if (mem_we !== 1'b0 || count !== 3'd2 || mem_addr !== 2'd2 || err !== 1'b1) begin bad++; $display("FAIL illegal_hold got we=%b cnt=%0d addr=%0d err=%b want 0/2/2/1", mem_we, count, mem_addr, err); end
    start = 1'b1;
    tick(); clr();
    vec++; if (err !== 1'b0 || count !== 3'd0 || mem_addr !== 2'd0) begin bad++; $display("FAIL start_clears got err=%b cnt=%0d addr=%0d want 0/0/0", err, count, mem_addr); end
  endtask
  task automatic test_imm_range();
    req(6'd15, 5'd1, 5'd0, 5'd0, 32'd4096, 1'b0, 1'b1);
    tick(); clr();
`ifdef ENC_IMM_RANGE_CHECK_EN
    vec++; if (err !== 1'b1 || mem_we !== 1'b0) begin bad++; $display("FAIL imm_range got err=%b we=%b want 1/0", err, mem_we); end
`else
    vec++; if (err !== 1'b0 || mem_we !== 1'b1 || mem_wdata !== 32'h00000093) begin bad++; $display("FAIL imm_trunc got err=%b we=%b %h want 0/1 00000093", err, mem_we, mem_wdata); end
`endif
    tick();
  endtask
  task automatic test_wrap();
    for (int i = 0; i < 5; i++) begin
      req(6'd15, 5'd1, 5'd0, 5'd0, 32'd1, 1'b0, i == 0);
      tick(); clr();
      vec++; if (mem_we !== 1'b1 || mem_addr !== 2'(i % 4)) begin bad++; $display("FAIL wrap_addr_%0d got we=%b addr=%0d want 1/%0d", i, mem_we, mem_addr, i % 4); end
      tick();
      vec++; if (count !== 3'((i < 4) ? i + 1 : 4)) begin bad++; $display("FAIL wrap_count_%0d got %0d want %0d", i, count, (i < 4) ? i + 1 : 4); end
    end
  endtask
  task automatic test_reset_inflight();
    mem_ready = 1'b0;
    req(6'd15, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0, 1'b1);
    tick(); clr();
    #2 rst_n = 1'b0;
    #1;
    vec++; if (mem_we !== 1'b0 || mem_addr !== 2'd0 || mem_wdata !== 32'h0 || count !== 3'd0) begin bad++; $display("FAIL async_reset got we=%b addr=%0d wdata=%h cnt=%0d want 0/0/0/0", mem_we, mem_addr, mem_wdata, count); end
    mem_ready = 1'b1;
    #2 rst_n = 1'b1;
    tick();
    vec++; if (in_ready !== 1'b1 || mem_we !== 1'b0 || count !== 3'd0) begin bad++; $display("FAIL reset_abandon got rdy=%b we=%b cnt=%0d want 1/0/0", in_ready, mem_we, count); end
  endtask
  initial begin
    test_reset();
    test_addi();
    test_r_type();
    test_formats();
    test_stall();
    test_illegal();
    test_imm_range();
    test_wrap();
    test_reset_inflight();
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end
endmodule
